// File: rtl/gb_timer_pkg.sv
// Shared Game Boy timer register constants.
//   Register addresses as decoded from the 2-bit addr bus (DIV/TIMA/TMA/TAC),
//   TAC field positions, the sysCnt bit tapped for each TAC clock select,
//   and the read-back format of TAC.
package gb_timer_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  // TAC fields: [2] timer enable, [1:0] input clock select
  localparam int unsigned TAC_EN_BIT  = 2;
  localparam int unsigned TAC_SEL_MSB = 1;
  localparam int unsigned TAC_SEL_LSB = 0;

  // sysCnt bit driving TIMA for each TAC clock select value
  localparam int unsigned TAC_SRC_BIT_00 = 9;
  localparam int unsigned TAC_SRC_BIT_01 = 3;
  localparam int unsigned TAC_SRC_BIT_10 = 5;
  localparam int unsigned TAC_SRC_BIT_11 = 7;

  // Unimplemented TAC bits read back as ones
  function automatic logic [7:0] tac_readback(input logic [2:0] tac);
    return {5'b11111, tac};
  endfunction

endpackage

// File: rtl/gb_timer_edge_detect.sv
// Rising-edge detector for a level generated synchronously to clk.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears the history register)
//   sig  : sampled level (e.g. gclk)
//   rise : high for one clk cycle while sig=1 and its registered copy is 0
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  always_ff @(posedge clk) begin
    if (rst) sig_prev <= 1'b0;
    else     sig_prev <= sig;
  end

  assign rise = sig & ~sig_prev;

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer block.
//   sclk   : system clock (only clock)
//   rst    : synchronous active-high reset
//   gclk   : divided Game Boy clock level; each rising edge is one tick
//   addr   : register select (DIV/TIMA/TMA/TAC)
//   wrEn   : one-cycle write strobe
//   wrData : write data
//   rdData : combinational read data of the selected register
//   irq    : one-cycle timer interrupt pulse on TIMA reload
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       gclk,
  input  logic [1:0] addr,
  input  logic       wrEn,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic       irq
);

  typedef enum logic {
    ST_RUN,
    ST_RELOAD_WAIT
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] sys_cnt;
  logic [7:0]           tima;
  logic [7:0]           tma;
  logic [2:0]           tac;
  logic [1:0]           wait_cnt;
  logic                 timer_in_prev;

  logic tick;
  logic src_bit;
  logic timer_in;
  logic tima_inc;
  logic reload;
  logic div_wr, tima_wr, tma_wr, tac_wr;

  edge_detect u_gclk_edge (
    .clk  (sclk),
    .rst  (rst),
    .sig  (gclk),
    .rise (tick)
  );

  assign div_wr  = wrEn && (addr == ADDR_DIV);
  assign tima_wr = wrEn && (addr == ADDR_TIMA);
  assign tma_wr  = wrEn && (addr == ADDR_TMA);
  assign tac_wr  = wrEn && (addr == ADDR_TAC);

  always_comb begin
    src_bit = 1'b0;
    case (tac[TAC_SEL_MSB:TAC_SEL_LSB])
      2'b00:   src_bit = sys_cnt[TAC_SRC_BIT_00];
      2'b01:   src_bit = sys_cnt[TAC_SRC_BIT_01];
      2'b10:   src_bit = sys_cnt[TAC_SRC_BIT_10];
      default: src_bit = sys_cnt[TAC_SRC_BIT_11];
    endcase
  end

  // Falling edge of the gated source bit; DIV/TAC writes can cause it too
  assign timer_in = tac[TAC_EN_BIT] & src_bit;
  assign tima_inc = timer_in_prev & ~timer_in;

  // Fourth tick after the overflow
  assign reload = (state == ST_RELOAD_WAIT) && tick && (wait_cnt == 2'd3);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state         <= ST_RUN;
      sys_cnt       <= '0;
      tima          <= '0;
      tma           <= '0;
      tac           <= '0;
      wait_cnt      <= '0;
      timer_in_prev <= 1'b0;
      irq           <= 1'b0;
    end else begin
      timer_in_prev <= timer_in;
      irq           <= reload;

      if (div_wr)    sys_cnt <= '0;
      else if (tick) sys_cnt <= sys_cnt + 1'b1;

      if (tma_wr) tma <= wrData;
      if (tac_wr) tac <= wrData[2:0];

      // Priority: reload > TIMA write > increment
      if (reload) begin
        tima     <= tma_wr ? wrData : tma;
        state    <= ST_RUN;
        wait_cnt <= '0;
      end else if (tima_wr) begin
        tima     <= wrData;
        state    <= ST_RUN;
        wait_cnt <= '0;
      end else begin
        if (state == ST_RELOAD_WAIT && tick) wait_cnt <= wait_cnt + 1'b1;
        if (tima_inc) begin
          if (tima == 8'hFF) begin
            tima     <= '0;
            state    <= ST_RELOAD_WAIT;
            wait_cnt <= '0;
          end else begin
            tima <= tima + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rdData = '0;
    case (addr)
      ADDR_DIV:  rdData = sys_cnt[15:8];
      ADDR_TIMA: rdData = tima;
      ADDR_TMA:  rdData = tma;
      default:   rdData = tac_readback(tac);
    endcase
  end

endmodule

// File: tb/tb_gb_timer.sv
module tb_gb_timer;
  import gb_timer_pkg::*;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       gclk = 1'b0;
  logic [1:0] addr = '0;
  logic       wrEn = 1'b0;
  logic [7:0] wrData = '0;
  logic [7:0] rdData;
  logic       irq;

  gb_timer #(.CNT_WIDTH(16)) dut (
    .sclk   (sclk),
    .rst    (rst),
    .gclk   (gclk),
    .addr   (addr),
    .wrEn   (wrEn),
    .wrData (wrData),
    .rdData (rdData),
    .irq    (irq)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_seen = 0;

  // Reference model: plain integers, rules applied once per sclk edge
  int m_sys, m_tima, m_tma, m_tac, m_wait;
  bit m_gprev, m_tinprev, m_pending, m_irq;

  function automatic int mread(input logic [1:0] a);
    case (a)
      2'd0:    return (m_sys / 256) % 256;
      2'd1:    return m_tima;
      2'd2:    return m_tma;
      default: return 248 + m_tac;
    endcase
  endfunction

  task automatic model_step(input bit g, input bit r, input logic [1:0] a,
                            input bit we, input int wd);
    int  taps[4];
    bit  tick, tin, fall, reload;
    int  tma_next;
    taps = '{9, 3, 5, 7};
    if (r) begin
      m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_wait = 0;
      m_gprev = 0; m_tinprev = 0; m_pending = 0; m_irq = 0;
      return;
    end
    tick   = g && !m_gprev;
    tin    = (m_tac >= 4) && (((m_sys >> taps[m_tac % 4]) % 2) == 1);
    fall   = m_tinprev && !tin;
    reload = m_pending && tick && (m_wait == 3);
    m_gprev   = g;
    m_tinprev = tin;
    m_irq     = reload;
    if (we && a == 0)  m_sys = 0;
    else if (tick)     m_sys = (m_sys + 1) % 65536;
    tma_next = (we && a == 2) ? wd : m_tma;
    if (reload) begin
      m_tima = tma_next; m_pending = 0; m_wait = 0;
    end else if (we && a == 1) begin
      m_tima = wd; m_pending = 0; m_wait = 0;
    end else begin
      if (m_pending && tick) m_wait++;
      if (fall) begin
        if (m_tima == 255) begin
          m_tima = 0; m_pending = 1; m_wait = 0;
        end else m_tima++;
      end
    end
    m_tma = tma_next;
    if (we && a == 3) m_tac = wd % 8;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One sclk cycle: drive on negedge, model at posedge, compare just after
  task automatic cyc(input bit g, input bit r, input logic [1:0] a,
                     input bit we, input logic [7:0] wd);
    @(negedge sclk);
    gclk = g; rst = r; addr = a; wrEn = we; wrData = wd;
    @(posedge sclk);
    model_step(g, r, a, we, int'(wd));
    #1;
    if (irq) irq_seen++;
    check("model_rd", int'(rdData), mread(a));
    check("model_irq", int'(irq), int'(m_irq));
  endtask

  task automatic gtick(input logic [1:0] a);
    cyc(1'b0, 1'b0, a, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, a, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, a, 1'b1, d);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, ADDR_DIV, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, ADDR_DIV, 1'b0, 8'h00);
  endtask

  task automatic overflow_setup();
    do_reset();
    wr(ADDR_TAC, 8'h05);
    wr(ADDR_TMA, 8'h80);
    wr(ADDR_TIMA, 8'hFF);
    wr(ADDR_DIV, 8'h00);
    repeat (16) gtick(ADDR_TIMA);
    cyc(1'b0, 1'b0, ADDR_TIMA, 1'b0, 8'h00);
    check("ovf_tima", int'(rdData), 0);
  endtask

  typedef struct {
    logic       we;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b0, ADDR_TAC,  8'h00, 8'hF8};
    tbl[1] = '{1'b1, ADDR_TAC,  8'h03, 8'hFB};
    tbl[2] = '{1'b1, ADDR_TAC,  8'hF8, 8'hF8};
    tbl[3] = '{1'b1, ADDR_TMA,  8'h5A, 8'h5A};
    tbl[4] = '{1'b1, ADDR_TIMA, 8'h33, 8'h33};
    tbl[5] = '{1'b1, ADDR_TAC,  8'h07, 8'hFF};
    tbl[6] = '{1'b1, ADDR_TIMA, 8'hC4, 8'hC4};
    tbl[7] = '{1'b1, ADDR_DIV,  8'hAB, 8'h00};
    tbl[8] = '{1'b1, ADDR_TMA,  8'hFF, 8'hFF};

    // Reset state and register table
    do_reset();
    check("rst_div", int'(rdData), 0);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
      cyc(1'b0, 1'b0, tbl[i].a, 1'b0, 8'h00);
      check($sformatf("tbl%0d", i), int'(rdData), int'(tbl[i].exp));
    end

    // 256 ticks with timer disabled
    do_reset();
    irq_seen = 0;
    repeat (256) gtick(ADDR_DIV);
    check("div_256", int'(rdData), 1);
    cyc(1'b0, 1'b0, ADDR_TIMA, 1'b0, 8'h00);
    check("tima_256", int'(rdData), 0);
    check("irq_256", irq_seen, 0);

    // Overflow and reload with TMA
    do_reset();
    wr(ADDR_TAC, 8'h05);
    wr(ADDR_TMA, 8'h80);
    wr(ADDR_TIMA, 8'hFE);
    wr(ADDR_DIV, 8'h00);
    irq_seen = 0;
    repeat (32) gtick(ADDR_TIMA);
    cyc(1'b0, 1'b0, ADDR_TIMA, 1'b0, 8'h00);
    check("wrap_tima", int'(rdData), 0);
    check("wrap_noirq", irq_seen, 0);
    repeat (4) gtick(ADDR_TIMA);
    check("reload_tima", int'(rdData), 8'h80);
    check("reload_irqs", irq_seen, 1);

    // DIV write causing a falling edge on the selected bit
    do_reset();
    wr(ADDR_TAC, 8'h05);
    repeat (8) gtick(ADDR_DIV);
    cyc(1'b0, 1'b0, ADDR_TIMA, 1'b0, 8'h00);
    check("divfall_pre", int'(rdData), 0);
    wr(ADDR_DIV, 8'h5C);
    check("divfall_div", int'(rdData), 0);
    cyc(1'b0, 1'b0, ADDR_TIMA, 1'b0, 8'h00);
    check("divfall_tima", int'(rdData), 1);

    // TIMA write cancels pending reload
    overflow_setup();
    irq_seen = 0;
    repeat (2) gtick(ADDR_TIMA);
    wr(ADDR_TIMA, 8'h10);
    repeat (6) gtick(ADDR_TIMA);
    check("cancel_tima", int'(rdData), 8'h10);
    check("cancel_irq", irq_seen, 0);

    // gclk held high counts once
    do_reset();
    repeat (100) cyc(1'b1, 1'b0, ADDR_DIV, 1'b0, 8'h00);
    repeat (254) gtick(ADDR_DIV);
    check("hold_div255", int'(rdData), 0);
    gtick(ADDR_DIV);
    check("hold_div256", int'(rdData), 1);

    // Reset during reload wait
    overflow_setup();
    irq_seen = 0;
    repeat (2) gtick(ADDR_TIMA);
    cyc(1'b0, 1'b1, ADDR_TIMA, 1'b1, 8'h77);
    repeat (6) gtick(ADDR_TIMA);
    check("rstwait_tima", int'(rdData), 0);
    check("rstwait_irq", irq_seen, 0);

    // Timer disabled never increments
    do_reset();
    wr(ADDR_TAC, 8'h03);
    check("tac03_rd", int'(rdData), 8'hFB);
    repeat (300) gtick(ADDR_TIMA);
    check("dis_tima", int'(rdData), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      bit         we, r, g;
      a  = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 399) == 0);
      g  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (a == ADDR_TAC) d[2] = ($urandom_range(0, 3) != 0);
      if (a == ADDR_TIMA && $urandom_range(0, 1) == 1) d[7:3] = 5'b11111;
      if (a == ADDR_DIV && $urandom_range(0, 3) != 0) we = 1'b0;
      cyc(g, r, a, we, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
